// File: rtl/mips_dm_pkg.sv
// Shared definitions for the latency-configurable MIPS data-memory stage:
// FSM encodings, access-direction constants and a constant-foldable clog2.
package mips_dm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dm_state_e;

  localparam logic MEM_STORE = 1'b1;
  localparam logic MEM_LOAD  = 1'b0;

  // Ceiling log2; returns 0 for n <= 1 so it can size a counter of value 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-addressed data RAM: synchronous write, asynchronous read, and every
// word cleared to zero while reset is asserted.
module dm_ram
  import mips_dm_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_reg [DEPTH];

  // One register per word so the whole array can be cleared asynchronously.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (we && (waddr == AW'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/data_memory_lat.sv
// MEM stage between EX and WB: load/store with READ_LAT-cycle loads, a stall
// while a load is in flight, out-of-range flagging and the writeback mux.
module data_memory_lat
  import mips_dm_pkg::*;
#(
  parameter int DW       = 16,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ans_ex,
  input  logic [DW-1:0] DM_data,
  input  logic          mem_rw_ex,
  input  logic          mem_en_ex,
  input  logic          mem_mux_sel_dm,
  output logic [DW-1:0] ans_dm,
  output logic          dm_busy,
  output logic          dm_err
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(READ_LAT) + 1;

  dm_state_e     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          sel_reg, sel_next;
  logic          oor_reg, oor_next;
  logic [DW-1:0] hold_reg, hold_next;
  logic [DW-1:0] ans_dm_reg, ans_dm_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;

  logic          oor_now;
  logic [AW-1:0] addr_now;
  logic          ram_we;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] rd_data;

  // Any set bit above the word address is an error; addresses never alias.
  if (DW > AW) begin : g_range
    assign oor_now = |ans_ex[DW-1:AW];
  end else begin : g_no_range
    assign oor_now = 1'b0;
  end

  assign addr_now  = AW'(ans_ex);
  assign ram_we    = (state_reg == IDLE) && mem_en_ex &&
                     (mem_rw_ex == MEM_STORE) && !oor_now;
  assign ram_raddr = (state_reg == WAIT) ? addr_reg : addr_now;
  assign rd_data   = ((state_reg == WAIT) ? oor_reg : oor_now) ? '0 : ram_rdata;

  dm_ram #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(addr_now),
    .wdata(DM_data),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      sel_reg    <= 1'b0;
      oor_reg    <= 1'b0;
      hold_reg   <= '0;
      ans_dm_reg <= '0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      sel_reg    <= sel_next;
      oor_reg    <= oor_next;
      hold_reg   <= hold_next;
      ans_dm_reg <= ans_dm_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    sel_next    = sel_reg;
    oor_next    = oor_reg;
    hold_next   = hold_reg;
    ans_dm_next = ans_dm_reg;
    busy_next   = busy_reg;
    err_next    = err_reg;

    case (state_reg)
      IDLE: begin
        if (!mem_en_ex) begin
          ans_dm_next = ans_ex;
          err_next    = 1'b0;
        end else if (mem_rw_ex == MEM_STORE) begin
          ans_dm_next = ans_ex;
          err_next    = oor_now;
        end else if (READ_LAT == 1) begin
          ans_dm_next = mem_mux_sel_dm ? rd_data : ans_ex;
          err_next    = oor_now;
        end else begin
          // Capture the request; upstream is stalled until the result lands.
          addr_next  = addr_now;
          sel_next   = mem_mux_sel_dm;
          oor_next   = oor_now;
          hold_next  = ans_ex;
          cnt_next   = CW'(READ_LAT - 1);
          busy_next  = 1'b1;
          err_next   = 1'b0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          ans_dm_next = sel_reg ? rd_data : hold_reg;
          err_next    = oor_reg;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ans_dm  = ans_dm_reg;
  assign dm_busy = busy_reg;
  assign dm_err  = err_reg;

endmodule

// File: tb/tb_data_memory_lat.sv
// Self-checking bench for data_memory_lat at READ_LAT = 1, 2 and 4, using a
// transaction-level memory model plus fixed vectors and corner sequences.
module tb_data_memory_lat;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int ND    = 3;
  localparam int LATS [ND] = '{1, 2, 4};

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ans_ex   [ND];
  logic [DW-1:0] dm_data  [ND];
  logic          rw       [ND];
  logic          en       [ND];
  logic          sel      [ND];
  logic [DW-1:0] ans_dm   [ND];
  logic          busy     [ND];
  logic          err      [ND];

  logic [DW-1:0] ref_mem  [ND][DEPTH];
  logic [DW-1:0] last_ans [ND];
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        en;
    logic        rw;
    logic        sel;
    logic [15:0] ans;
    logic [15:0] data;
    logic [15:0] exp_ans;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    data_memory_lat #(
      .DW(DW), .DEPTH(DEPTH), .READ_LAT(LATS[gi])
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .ans_ex        (ans_ex[gi]),
      .DM_data       (dm_data[gi]),
      .mem_rw_ex     (rw[gi]),
      .mem_en_ex     (en[gi]),
      .mem_mux_sel_dm(sel[gi]),
      .ans_dm        (ans_dm[gi]),
      .dm_busy       (busy[gi]),
      .dm_err        (err[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      last_ans[d] = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = '0;
    end
  endtask

  task automatic set_idle(input int d, input logic [15:0] a);
    en[d] = 1'b0; rw[d] = 1'b0; sel[d] = 1'b0; ans_ex[d] = a; dm_data[d] = '0;
  endtask

  // Called at posedge+1; drives one access, rides out any stall, checks result.
  task automatic apply(input int d, input logic e, input logic w, input logic s,
                       input logic [15:0] a, input logic [15:0] data,
                       input logic [15:0] exp_ans, input logic exp_err,
                       input int exp_busy, input string tag);
    int busy_cnt;
    en[d] = e; rw[d] = w; sel[d] = s; ans_ex[d] = a; dm_data[d] = data;
    @(posedge clk); #1;
    busy_cnt = 0;
    while (busy[d] === 1'b1 && busy_cnt < 10) begin
      busy_cnt++;
      check({tag, " hold"}, 32'(ans_dm[d]), 32'(last_ans[d]));
      en[d] = 1'($urandom); rw[d] = 1'($urandom); sel[d] = 1'($urandom);
      ans_ex[d] = 16'($urandom_range(0, DEPTH - 1)); dm_data[d] = 16'($urandom);
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " ans_dm"}, 32'(ans_dm[d]), 32'(exp_ans));
    check({tag, " dm_err"}, 32'(err[d]), 32'(exp_err));
    $display("txn %s lat=%0d en=%0b rw=%0b sel=%0b addr=%h data=%h -> ans_dm=%h err=%0b stall=%0d",
             tag, LATS[d], e, w, s, a, data, ans_dm[d], err[d], busy_cnt);
    if (e && w && a < DEPTH) ref_mem[d][a] = data;
    last_ans[d] = exp_ans;
    set_idle(d, exp_ans);
  endtask

  // Expected values derived from the access rules, then applied.
  task automatic do_txn(input int d, input logic e, input logic w, input logic s,
                        input logic [15:0] a, input logic [15:0] data, input string tag);
    logic        oor;
    logic [15:0] exp_ans;
    int          exp_busy;
    oor = (a >= DEPTH);
    if (!e || w) exp_ans = a;
    else if (s) exp_ans = oor ? 16'h0000 : ref_mem[d][a];
    else exp_ans = a;
    exp_busy = (e && !w) ? LATS[d] - 1 : 0;
    apply(d, e, w, s, a, data, exp_ans, e && oor, exp_busy, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed vectors for READ_LAT=2 (store/load, mux select, range errors).
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF, 16'h0003, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, 16'hFFFF, 1'b0, 1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0003, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF, 16'h0040, 1'b1, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0055, 16'h0000, 16'h0055, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h003F, 16'h1234, 16'h003F, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h003F, 16'h0000, 16'h1234, 1'b0, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1};

    // Reset with pass-through input present.
    clear_model();
    for (int d = 0; d < ND; d++) set_idle(d, 16'h1234);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      check("reset ans_dm", 32'(ans_dm[d]), 32'h0);
      check("reset dm_busy", 32'(busy[d]), 32'h0);
      check("reset dm_err", 32'(err[d]), 32'h0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      check("pass-through ans_dm", 32'(ans_dm[d]), 32'h1234);
      check("pass-through dm_err", 32'(err[d]), 32'h0);
      last_ans[d] = 16'h1234;
    end

    for (int i = 0; i < 11; i++)
      apply(1, vecs[i].en, vecs[i].rw, vecs[i].sel, vecs[i].ans, vecs[i].data,
            vecs[i].exp_ans, vecs[i].exp_err, vecs[i].exp_busy, $sformatf("vec%0d", i));

    // Latency sweep corner: store then immediate load at READ_LAT 1 and 4.
    do_txn(0, 1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF, "lat1 store");
    do_txn(0, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, "lat1 load");
    do_txn(2, 1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF, "lat4 store");
    do_txn(2, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, "lat4 load");
    do_txn(2, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, "lat4 oor load");

    // Randomized traffic against the model on every latency.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 40; n++) begin
        logic [15:0] a;
        a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
        do_txn(d, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               a, 16'($urandom), $sformatf("rand%0d", n));
      end
    end

    // Reset during the second WAIT cycle of a READ_LAT=4 load.
    do_txn(2, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h5A5A, "pre-reset store");
    en[2] = 1'b1; rw[2] = 1'b0; sel[2] = 1'b1; ans_ex[2] = 16'h0003;
    @(posedge clk); #1;
    check("midload busy", 32'(busy[2]), 32'h1);
    @(posedge clk); #2;
    for (int d = 0; d < ND; d++) set_idle(d, 16'h0000);
    reset = 1'b1;
    #1;
    check("async reset dm_busy", 32'(busy[2]), 32'h0);
    check("async reset ans_dm", 32'(ans_dm[2]), 32'h0);
    clear_model();
    @(posedge clk); #1;
    reset = 1'b0;
    do_txn(2, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, "post-reset load");
    do_txn(1, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, "post-reset lat2 load");
    do_txn(0, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, "post-reset lat1 load");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
